// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply, restoring divide.
// 33 busy cycles per op (1 for divide-by-zero); stalls EX while busy and drops MT writes.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  input  logic             i_abort,
  input  logic             i_mf_rd,
  input  logic             i_mt_wr,
  input  logic             i_hilo_sel,
  input  logic [WIDTH-1:0] i_mt_data,
  output logic [WIDTH-1:0] o_mf_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_a;
  logic                 r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_busy, r_done;

  logic                 w_accept, w_dbz, w_last;
  logic                 w_write_hilo, w_mt_en;
  logic                 w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
  logic [WIDTH:0]       w_mul_sum, w_div_shift;
  logic [2*WIDTH-1:0]   w_mul_acc, w_div_acc, w_prod;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_sub, w_div_rem, w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_dbz    = i_op[1] && (i_rt_data == '0);
  assign w_last   = (r_cnt == LAST_CNT);

  // Signed ops (op[0]==0) run on magnitudes; signs are reapplied in FIX.
  assign w_rs_neg = !i_op[0] && i_rs_data[WIDTH-1];
  assign w_rt_neg = !i_op[0] && i_rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -i_rs_data : i_rs_data;
  assign w_rt_mag = w_rt_neg ? -i_rt_data : i_rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_a;
  assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
  assign w_div_acc   = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_dbz ? S_FIX : S_RUN;
      S_RUN:   if (i_abort) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_write_hilo = (r_state == S_FIX) && !i_abort;
    w_mt_en      = (r_state == S_IDLE) && i_mt_wr && !i_start;
    o_stall      = r_busy && (i_start || i_mf_rd || i_mt_wr);
    o_mf_data    = i_hilo_sel ? r_hi : r_lo;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_write_hilo;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= i_op[1];
        if (w_dbz) begin
          r_acc   <= {i_rs_data, {WIDTH{1'b1}}};
          r_a     <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else if (i_op[1]) begin
          r_acc   <= {{WIDTH{1'b0}}, w_rs_mag};
          r_a     <= w_rt_mag;
          r_neg_q <= w_rs_neg ^ w_rt_neg;
          r_neg_r <= w_rs_neg;
        end else begin
          r_acc   <= {{WIDTH{1'b0}}, w_rt_mag};
          r_a     <= w_rs_mag;
          r_neg_q <= w_rs_neg ^ w_rt_neg;
          r_neg_r <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end
      if (w_write_hilo) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_en) begin
        if (i_hilo_sel) r_hi <= i_mt_data;
        else            r_lo <= i_mt_data;
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk, rst_n, start, abort, mf_rd, mt_wr, hilo_sel;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, mt_data;
  logic [31:0] mf_data, hi, lo;
  logic        busy, done, stall;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_abort(abort),
    .i_mf_rd(mf_rd), .i_mt_wr(mt_wr), .i_hilo_sel(hilo_sel),
    .i_mt_data(mt_data), .o_mf_data(mf_data), .o_hi(hi), .o_lo(lo),
    .o_busy(busy), .o_done(done), .o_stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (m_op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op, count busy cycles, then check result, done pulse and latency.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    int exp_n;
    logic early_done;
    exp_n = (o[1] && b == 32'h0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    early_done = 1'b0;
    while (busy && n < 200) begin
      if (done) early_done = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_early_done"}, {31'b0, early_done}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h1);
    chk({tag, "_hi"}, hi, exp[63:32]);
    chk({tag, "_lo"}, lo, exp[31:0]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] keep_hi, keep_lo;
    logic [1:0]  r_op;
    logic [31:0] ra, rb;
    int n;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mf_rd = 1'b0; mt_wr = 1'b0;
    hilo_sel = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; mt_data = '0;

    // Reset state
    @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;

    // Directed corner results
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});

    // mf_rd/mt_wr during busy: stall, MT dropped, then honoured once idle
    e = model(2'b01, 32'h1234_5678, 32'h9ABC_DEF1);
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (n == 5) begin
        mf_rd = 1'b1; mt_wr = 1'b1; hilo_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
        #1;
        chk("stall_busy", {31'b0, stall}, 32'h1);
      end
      n++;
      @(negedge clk);
    end
    chk("mf_busy_cycles", 32'(n), 32'd33);
    chk("stall_idle", {31'b0, stall}, 32'h0);
    chk("mf_new_hi", mf_data, e[63:32]);
    chk("mt_drop_hi", hi, e[63:32]);
    @(negedge clk);
    chk("mt_write_hi", hi, 32'hDEAD_BEEF);
    chk("mf_after_mt", mf_data, 32'hDEAD_BEEF);
    hilo_sel = 1'b0; mt_data = 32'h0BAD_F00D;
    @(negedge clk);
    mt_wr = 1'b0; mf_rd = 1'b0;
    chk("mt_write_lo", mf_data, 32'h0BAD_F00D);
    chk("mt_keep_hi", hi, 32'hDEAD_BEEF);

    // start and mt_wr together in IDLE: start wins
    e = model(2'b11, 32'd1000, 32'd7);
    @(negedge clk);
    start = 1'b1; mt_wr = 1'b1; hilo_sel = 1'b0; mt_data = 32'h5555_5555;
    op = 2'b11; rs_data = 32'd1000; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; mt_wr = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("startwin_cycles", 32'(n), 32'd33);
    chk("startwin_lo", lo, e[31:0]);
    chk("startwin_hi", hi, e[63:32]);

    // Abort mid-run
    keep_hi = hi; keep_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'($urandom); rt_data = 32'($urandom_range(1, 99));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 10) begin n++; @(negedge clk); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_hi", hi, keep_hi);
    chk("abort_lo", lo, keep_lo);
    @(negedge clk);
    chk("abort_done2", {31'b0, done}, 32'h0);
    chk("abort_hi2", hi, keep_hi);
    run_op("after_abort", 2'b00, 32'hFFFF_F000, 32'h0000_0123, model(2'b00, 32'hFFFF_F000, 32'h0000_0123));

    // Asynchronous reset mid-run
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'hCAFE_0001; rt_data = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42});

    // Randomized ops against the model
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      run_op("rand", r_op, ra, rb, model(r_op, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
